riscv_mem_arbiter: RTL and testbench
====================================

Name: riscv_mem_arbiter

Overview:
- Shares one single-port, unified instruction/data memory between the pipelined core's instruction-fetch (IF) port and its load/store (D) port.
- Grants at most one access per cycle.
- Routes the 1-cycle-latency read data back to the port that issued the read.
- Sits between the pipelined CPU and the memory in the top level. The core stalls on any cycle where its request is not granted.

Parameters:
- XLEN, 32, data and address width.
- STARVE_MAX, 3, consecutive denied IF cycles after which IF wins a conflict (range 1..15).

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous reset, active-high
- i_if_req  in  1  IF read request
- i_if_addr  in  XLEN  IF byte address
- o_if_gnt  out  1  IF request accepted this cycle
- o_if_rvalid  out  1  IF read data valid
- o_if_rdata  out  XLEN  IF read data
- i_d_req  in  1  D request
- i_d_wr_en  in  1  1 = store, 0 = load
- i_d_byte_sel  in  4  store byte enables
- i_d_addr  in  XLEN  D byte address
- i_d_wr_data  in  XLEN  store data
- o_d_gnt  out  1  D request accepted this cycle
- o_d_rvalid  out  1  D load data valid
- o_d_rdata  out  XLEN  D load data
- o_mem_en  out  1  memory access strobe
- o_mem_wr_en  out  1  memory write
- o_mem_byte_sel  out  4  memory byte enables
- o_mem_addr  out  XLEN  memory address
- o_mem_wr_data  out  XLEN  memory write data
- i_mem_rd_data  in  XLEN  read data, valid the cycle after a read strobe

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Handshake:
  - A requester holds req, addr and data stable until it sees gnt high.
  - gnt is combinational from req and the arbiter state, so a grant can come in the same cycle as the request.
  - A request is transferred on any cycle where req and gnt are both high.
  - o_if_gnt and o_d_gnt are never both 1.
- Memory command (combinational from the winner):
  - o_mem_en = o_if_gnt | o_d_gnt.
  - addr comes from the winner.
  - o_mem_wr_en = o_d_gnt & i_d_wr_en.
  - o_mem_byte_sel = 4'hF for IF grants and for D loads; i_d_byte_sel for D stores.
  - o_mem_wr_data = i_d_wr_data.
  - When idle, all memory outputs are 0.
- Arbitration (default, fixed priority with anti-starvation):
  - Only IF requesting: IF granted.
  - Only D requesting: D granted.
  - Both requesting: D granted unless starve_cnt == STARVE_MAX, in which case IF is granted.
- starve_cnt (4-bit register):
  - Increments, saturating at STARVE_MAX, when i_if_req=1 and o_if_gnt=0.
  - Clears to 0 when IF is granted or i_if_req=0.
- Response tracking:
  - Registered rsp_owner in {NONE, IF, D}, updated every cycle:
    - IF on an IF grant.
    - D on a D load grant.
    - NONE on a D store or no grant.
  - Next cycle: o_if_rvalid = (rsp_owner==IF) and o_d_rvalid = (rsp_owner==D).
  - rdata = i_mem_rd_data when the matching rvalid is high, else 0.
- Latency:
  - Grant-to-rvalid is exactly 1 cycle.
  - Throughput is one access per cycle, so back-to-back grants are allowed.
- Reset:
  - While i_rst=1: o_if_gnt=0, o_d_gnt=0, o_mem_en=0 and all memory outputs are 0.
  - Reset clears starve_cnt=0 and rsp_owner=NONE.
  - o_*_rvalid=0 and o_*_rdata=0 from the first cycle after a reset edge.
- Reset mid-operation: a read granted in the cycle before i_rst rises gets no rvalid, and its response is dropped.
- Simultaneous events: a D store and an IF fetch requested in the same cycle are serialised. The loser sees gnt=0 and retries the next cycle with its request held.

Optional Feature:
- Macro: RISCV_ARB_RR_EN.
- Defined:
  - Conflicts are resolved round-robin using a 1-bit last_gnt register, updated on every grant.
  - On a conflict, the port not granted last wins.
  - starve_cnt is held at 0 and unused.
- Undefined: the fixed-priority plus STARVE_MAX scheme above. last_gnt is not implemented.

Test Plan:
1. Reset: hold i_rst=1 for 3 cycles with both reqs high -> both gnt=0, o_mem_en=0, both rvalid=0. Release reset -> the grant appears in the first cycle.
2. IF only: i_if_req=1, addr 0x0, 0x4, 0x8 on consecutive cycles, memory preloaded with 0x00500113, 0x00C00193, 0xFF718393 -> o_if_gnt=1 each cycle. o_if_rvalid=1 one cycle later, with o_if_rdata equal to those words in order.
3. D store then load: store 0xDEADBEEF to 0x60 with byte_sel 4'b0011, then load 0x60 -> o_mem_byte_sel=0011 then 1111. o_d_rvalid=1 exactly one cycle after the load grant. No rvalid follows the store.
4. Starvation (default): both reqs held high for 8 cycles, STARVE_MAX=3 -> grant sequence D,D,D,IF,D,D,D,IF. starve_cnt reaches 3 before each IF grant.
5. RISCV_ARB_RR_EN defined: both reqs held high for 6 cycles, last_gnt=IF after reset -> grants D,IF,D,IF,D,IF.
6. Reset mid-read: IF granted for addr 0x10 at cycle N, i_rst=1 at cycle N+1 -> o_if_rvalid stays 0 at N+1 and after, and rsp_owner=NONE after release.

Source files
------------

// File: rtl/riscv_mem_arbiter_if.sv
// Bundle of the core-side (IF and D ports) and memory-side signals shared
// by riscv_mem_arbiter.
// Optional build macro used by the arbiter: RISCV_ARB_RR_EN.
// Handshake (both request ports): a requester raises req and holds req, addr
// and data stable until it sees gnt high. gnt is combinational, so a request
// can be accepted in the same cycle it appears. A transfer happens on every
// cycle with req && gnt. Read data returns exactly one cycle after the grant,
// flagged by the port's rvalid.
interface riscv_mem_arbiter_if #(
  parameter int XLEN = 32
);
  // instruction-fetch port
  logic            i_if_req;
  logic [XLEN-1:0] i_if_addr;
  logic            o_if_gnt;
  logic            o_if_rvalid;
  logic [XLEN-1:0] o_if_rdata;
  // load/store port
  logic            i_d_req;
  logic            i_d_wr_en;
  logic [3:0]      i_d_byte_sel;
  logic [XLEN-1:0] i_d_addr;
  logic [XLEN-1:0] i_d_wr_data;
  logic            o_d_gnt;
  logic            o_d_rvalid;
  logic [XLEN-1:0] o_d_rdata;
  // single-port memory
  logic            o_mem_en;
  logic            o_mem_wr_en;
  logic [3:0]      o_mem_byte_sel;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wr_data;
  logic [XLEN-1:0] i_mem_rd_data;

  // arbiter view
  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_d_req, i_d_wr_en, i_d_byte_sel, i_d_addr, i_d_wr_data,
    output o_d_gnt, o_d_rvalid, o_d_rdata,
    output o_mem_en, o_mem_wr_en, o_mem_byte_sel, o_mem_addr, o_mem_wr_data,
    input  i_mem_rd_data
  );

  // environment view (core + memory)
  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_d_req, i_d_wr_en, i_d_byte_sel, i_d_addr, i_d_wr_data,
    input  o_d_gnt, o_d_rvalid, o_d_rdata,
    input  o_mem_en, o_mem_wr_en, o_mem_byte_sel, o_mem_addr, o_mem_wr_data,
    output i_mem_rd_data
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-port unified memory between the
// core's instruction-fetch port and its load/store port. At most one access
// is granted per cycle; read data (1-cycle latency) is steered back to the
// port that issued the read.
// Build macro RISCV_ARB_RR_EN: when defined, conflicts are resolved
// round-robin via last_gnt; when undefined, D has priority and IF wins a
// conflict once it has been denied STARVE_MAX cycles in a row.
// Debug outputs expose starve_cnt, the response-owner state and last_gnt.
module riscv_mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  riscv_mem_arbiter_if.slave   bus,
  output logic [3:0]           o_dbg_starve_cnt,
  output logic [1:0]           o_dbg_rsp_owner,
  output logic                 o_dbg_last_gnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_e     rsp_owner_q, rsp_owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       if_gnt, d_gnt;
  logic       conflict, if_wins;

`ifdef RISCV_ARB_RR_EN
  // last_gnt: 1 = IF was granted last, 0 = D was granted last.
  logic       last_gnt_q, last_gnt_d;
`endif

  // Arbitration: grants are combinational so a request can be taken the
  // same cycle it is raised; nothing is granted while reset is asserted.
  always_comb begin
    conflict = bus.i_if_req & bus.i_d_req;
`ifdef RISCV_ARB_RR_EN
    if_wins  = ~last_gnt_q;
`else
    if_wins  = (starve_cnt_q == STARVE_LIM);
`endif
    if_gnt   = 1'b0;
    d_gnt    = 1'b0;
    if (!i_rst) begin
      if (conflict) begin
        if_gnt = if_wins;
        d_gnt  = ~if_wins;
      end else begin
        if_gnt = bus.i_if_req;
        d_gnt  = bus.i_d_req;
      end
    end
  end

  // Memory command driven from the winner; all zero when nobody is granted.
  always_comb begin
    bus.o_mem_en       = 1'b0;
    bus.o_mem_wr_en    = 1'b0;
    bus.o_mem_byte_sel = 4'h0;
    bus.o_mem_addr     = '0;
    bus.o_mem_wr_data  = '0;
    if (if_gnt) begin
      bus.o_mem_en       = 1'b1;
      bus.o_mem_byte_sel = 4'hF;
      bus.o_mem_addr     = bus.i_if_addr;
      bus.o_mem_wr_data  = bus.i_d_wr_data;
    end else if (d_gnt) begin
      bus.o_mem_en       = 1'b1;
      bus.o_mem_wr_en    = bus.i_d_wr_en;
      bus.o_mem_byte_sel = bus.i_d_wr_en ? bus.i_d_byte_sel : 4'hF;
      bus.o_mem_addr     = bus.i_d_addr;
      bus.o_mem_wr_data  = bus.i_d_wr_data;
    end
  end

  // Next-state for the starvation counter, response owner and last_gnt.
  always_comb begin
`ifdef RISCV_ARB_RR_EN
    starve_cnt_d = 4'd0;
    last_gnt_d   = last_gnt_q;
    if (if_gnt) begin
      last_gnt_d = 1'b1;
    end else if (d_gnt) begin
      last_gnt_d = 1'b0;
    end
`else
    starve_cnt_d = 4'd0;
    if (bus.i_if_req && !if_gnt) begin
      starve_cnt_d = (starve_cnt_q >= STARVE_LIM) ? STARVE_LIM
                                                  : starve_cnt_q + 4'd1;
    end
`endif
    rsp_owner_d = OWN_NONE;
    if (if_gnt) begin
      rsp_owner_d = OWN_IF;
    end else if (d_gnt && !bus.i_d_wr_en) begin
      rsp_owner_d = OWN_D;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt_q <= 4'd0;
      rsp_owner_q  <= OWN_NONE;
`ifdef RISCV_ARB_RR_EN
      last_gnt_q   <= 1'b1;
`endif
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_owner_q  <= rsp_owner_d;
`ifdef RISCV_ARB_RR_EN
      last_gnt_q   <= last_gnt_d;
`endif
    end
  end

  // Response steering. rvalid is masked while reset is high so a read
  // granted the cycle before reset rises never reports data.
  always_comb begin
    bus.o_if_gnt    = if_gnt;
    bus.o_d_gnt     = d_gnt;
    bus.o_if_rvalid = (rsp_owner_q == OWN_IF) & ~i_rst;
    bus.o_d_rvalid  = (rsp_owner_q == OWN_D) & ~i_rst;
    bus.o_if_rdata  = bus.o_if_rvalid ? bus.i_mem_rd_data : '0;
    bus.o_d_rdata   = bus.o_d_rvalid ? bus.i_mem_rd_data : '0;
  end

  // Debug visibility of internal state.
  always_comb begin
    o_dbg_starve_cnt = starve_cnt_q;
    o_dbg_rsp_owner  = rsp_owner_q;
`ifdef RISCV_ARB_RR_EN
    o_dbg_last_gnt   = last_gnt_q;
`else
    o_dbg_last_gnt   = 1'b0;
`endif
  end

`ifndef SYNTHESIS
  // Structural invariants of the arbiter.
  a_one_hot_gnt : assert property (@(posedge i_clk) !(bus.o_if_gnt && bus.o_d_gnt));
  a_en_matches  : assert property (@(posedge i_clk) bus.o_mem_en == (bus.o_if_gnt | bus.o_d_gnt));
  a_cnt_bound   : assert property (@(posedge i_clk) starve_cnt_q <= STARVE_LIM);
  a_rst_quiet   : assert property (@(posedge i_clk) i_rst |-> !bus.o_mem_en);
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter. A behavioural memory sits on the
// memory side; a reference copy of that memory plus a small arbitration
// model supply expected grants and read data, queued at grant time and
// popped when the matching rvalid is due.
module tb_riscv_mem_arbiter;
  localparam int XLEN = 32;
  localparam int SMAX = 3;

  logic       clk;
  logic       rst;
  logic [3:0] dbg_starve;
  logic [1:0] dbg_owner;
  logic       dbg_last;

  riscv_mem_arbiter_if #(.XLEN(XLEN)) bus ();

  riscv_mem_arbiter #(.XLEN(XLEN), .STARVE_MAX(SMAX)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .bus              (bus),
    .o_dbg_starve_cnt (dbg_starve),
    .o_dbg_rsp_owner  (dbg_owner),
    .o_dbg_last_gnt   (dbg_last)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model and reference copy
  logic [XLEN-1:0] mem     [0:63];
  logic [XLEN-1:0] ref_mem [0:63];
  logic [XLEN-1:0] exp_if_q[$];
  logic [XLEN-1:0] exp_d_q[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      if (bus.o_mem_wr_en) begin
        for (int b = 0; b < 4; b++)
          if (bus.o_mem_byte_sel[b]) mem[bus.o_mem_addr[7:2]][8*b +: 8] <= bus.o_mem_wr_data[8*b +: 8];
      end
      bus.i_mem_rd_data <= mem[bus.o_mem_addr[7:2]];
    end
  end

  // scoreboard / reference model, evaluated mid-cycle
  logic       pend_if = 1'b0, pend_d = 1'b0;
  logic [3:0] m_cnt   = 4'd0;
  logic       m_last  = 1'b1;
  logic       e_ig, e_dg, e_ifv, e_dv, e_if_wins;
  logic [XLEN-1:0] e;

  always @(negedge clk) begin
    // responses from last cycle's grants
    e_ifv = pend_if && !rst;
    e_dv  = pend_d && !rst;
    check("if_rvalid", bus.o_if_rvalid, e_ifv);
    check("d_rvalid", bus.o_d_rvalid, e_dv);
    if (pend_if) begin
      if (exp_if_q.size() == 0) check("if_q_underflow", 1, 0);
      else begin
        e = exp_if_q.pop_front();
        if (e_ifv) check("if_rdata", bus.o_if_rdata, e);
      end
    end
    if (!e_ifv) check("if_rdata_zero", bus.o_if_rdata, 0);
    if (pend_d) begin
      if (exp_d_q.size() == 0) check("d_q_underflow", 1, 0);
      else begin
        e = exp_d_q.pop_front();
        if (e_dv) check("d_rdata", bus.o_d_rdata, e);
      end
    end
    if (!e_dv) check("d_rdata_zero", bus.o_d_rdata, 0);

    // expected grants
`ifdef RISCV_ARB_RR_EN
    e_if_wins = !m_last;
`else
    e_if_wins = (m_cnt == 4'(SMAX));
`endif
    e_ig = 1'b0; e_dg = 1'b0;
    if (!rst) begin
      if (bus.i_if_req && bus.i_d_req) begin
        e_ig = e_if_wins; e_dg = !e_if_wins;
      end else begin
        e_ig = bus.i_if_req; e_dg = bus.i_d_req;
      end
    end
    check("if_gnt", bus.o_if_gnt, e_ig);
    check("d_gnt", bus.o_d_gnt, e_dg);
    check("mem_en", bus.o_mem_en, e_ig | e_dg);
    check("mem_wr_en", bus.o_mem_wr_en, e_dg & bus.i_d_wr_en);
    check("mem_bsel", bus.o_mem_byte_sel,
          e_ig ? 4'hF : (e_dg ? (bus.i_d_wr_en ? bus.i_d_byte_sel : 4'hF) : 4'h0));
    check("mem_addr", bus.o_mem_addr, e_ig ? bus.i_if_addr : (e_dg ? bus.i_d_addr : 0));
    check("mem_wdata", bus.o_mem_wr_data, (e_ig | e_dg) ? bus.i_d_wr_data : 0);

    // queue expected read data, apply stores to the reference
    pend_if = e_ig;
    pend_d  = e_dg && !bus.i_d_wr_en;
    if (e_ig) exp_if_q.push_back(ref_mem[bus.i_if_addr[7:2]]);
    if (pend_d) exp_d_q.push_back(ref_mem[bus.i_d_addr[7:2]]);
    if (e_dg && bus.i_d_wr_en)
      for (int b = 0; b < 4; b++)
        if (bus.i_d_byte_sel[b]) ref_mem[bus.i_d_addr[7:2]][8*b +: 8] = bus.i_d_wr_data[8*b +: 8];

    // model state for the coming edge
    if (rst) begin
      m_cnt = 4'd0; m_last = 1'b1;
    end else begin
`ifdef RISCV_ARB_RR_EN
      if (e_ig) m_last = 1'b1; else if (e_dg) m_last = 1'b0;
`else
      if (bus.i_if_req && !e_ig) m_cnt = (m_cnt >= 4'(SMAX)) ? 4'(SMAX) : m_cnt + 4'd1;
      else m_cnt = 4'd0;
`endif
    end
  end

  // driver tasks: inputs change just after the rising edge
  task automatic drive_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive_step();
    bus.i_if_req = 1'b0; bus.i_d_req = 1'b0; bus.i_d_wr_en = 1'b0;
    bus.i_d_byte_sel = 4'h0; bus.i_if_addr = '0; bus.i_d_addr = '0; bus.i_d_wr_data = '0;
  endtask

  task automatic wait_gnt(input bit is_if);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (is_if ? bus.o_if_gnt : bus.o_d_gnt) return;
    end
    check("gnt_timeout", 0, 1);
  endtask

  task automatic if_fetch(input logic [XLEN-1:0] a);
    drive_step();
    bus.i_if_req = 1'b1; bus.i_if_addr = a;
    wait_gnt(1'b1);
  endtask

  task automatic d_access(input logic wr, input logic [3:0] sel, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] wd, input logic [3:0] exp_bsel);
    drive_step();
    bus.i_if_req = 1'b0;
    bus.i_d_req = 1'b1; bus.i_d_wr_en = wr; bus.i_d_byte_sel = sel;
    bus.i_d_addr = a; bus.i_d_wr_data = wd;
    wait_gnt(1'b0);
    check("d_bsel", bus.o_mem_byte_sel, exp_bsel);
  endtask

  task automatic do_reset(input int n);
    drive_step();
    rst = 1'b1;
    repeat (n) drive_step();
    rst = 1'b0;
  endtask

  logic [XLEN-1:0] words [0:2];

  initial begin
    words[0] = 32'h00500113; words[1] = 32'h00C00193; words[2] = 32'hFF718393;
    for (int i = 0; i < 64; i++) begin
      mem[i] = (i < 3) ? words[i] : 32'h0;
      ref_mem[i] = mem[i];
    end
    bus.i_mem_rd_data = '0;
    rst = 1'b1;
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h0;
    bus.i_d_req = 1'b1; bus.i_d_wr_en = 1'b0; bus.i_d_byte_sel = 4'h0;
    bus.i_d_addr = 32'h60; bus.i_d_wr_data = '0;

    // reset held with both requests high
    repeat (3) begin
      @(negedge clk);
      check("rst_gnt", {bus.o_if_gnt, bus.o_d_gnt}, 2'b00);
      check("rst_mem_en", bus.o_mem_en, 0);
      check("rst_rvalid", {bus.o_if_rvalid, bus.o_d_rvalid}, 2'b00);
    end
    check("rst_starve", dbg_starve, 0);
    check("rst_owner", dbg_owner, 0);
    drive_step();
    rst = 1'b0;
    @(negedge clk);
    check("release_gnt", {bus.o_if_gnt, bus.o_d_gnt}, 2'b01);
    idle();

    // IF only, back-to-back fetches
    for (int i = 0; i < 3; i++) begin
      if_fetch(32'(4 * i));
      check("if_b2b_gnt", bus.o_if_gnt, 1);
    end
    idle();
    @(negedge clk);
    check("if_last_rdata", bus.o_if_rdata, words[2]);

    // store then load with partial byte enables
    d_access(1'b1, 4'b0011, 32'h60, 32'hDEADBEEF, 4'b0011);
    idle();
    @(negedge clk);
    check("store_no_rvalid", {bus.o_if_rvalid, bus.o_d_rvalid}, 2'b00);
    d_access(1'b0, 4'b0000, 32'h60, 32'h0, 4'hF);
    idle();
    @(negedge clk);
    check("load_rvalid", bus.o_d_rvalid, 1);
    check("load_rdata", bus.o_d_rdata, 32'h0000BEEF);

    // conflict sequence starting from a fresh reset
    do_reset(2);
    bus.i_if_req = 1'b1; bus.i_if_addr = 32'h4;
    bus.i_d_req = 1'b1; bus.i_d_wr_en = 1'b0; bus.i_d_addr = 32'h60;
    begin
`ifdef RISCV_ARB_RR_EN
      logic [5:0] pat, seen;
      pat = 6'b101010;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        seen[i] = bus.o_if_gnt;
        check("rr_starve_zero", dbg_starve, 0);
      end
      check("rr_pattern", seen, pat);
`else
      logic [7:0] pat, seen;
      pat = 8'b10001000;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        seen[i] = bus.o_if_gnt;
        if (bus.o_if_gnt) check("starve_at_if", dbg_starve, 4'(SMAX));
      end
      check("starve_pattern", seen, pat);
`endif
    end
    idle();

    // reset arriving right after an IF grant drops the response
    if_fetch(32'h10);
    drive_step();
    bus.i_if_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rvalid", bus.o_if_rvalid, 0);
    drive_step();
    @(negedge clk);
    check("midrst_rvalid2", bus.o_if_rvalid, 0);
    drive_step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_owner", dbg_owner, 0);
    check("midrst_rvalid3", bus.o_if_rvalid, 0);

    // random mixed traffic
    for (int i = 0; i < 60; i++) begin
      drive_step();
      bus.i_if_req = 1'($urandom_range(0, 1));
      bus.i_if_addr = 32'($urandom_range(0, 15)) << 2;
      bus.i_d_req = 1'($urandom_range(0, 1));
      bus.i_d_wr_en = 1'($urandom_range(0, 1));
      bus.i_d_byte_sel = 4'($urandom_range(0, 15));
      bus.i_d_addr = 32'($urandom_range(16, 31)) << 2;
      bus.i_d_wr_data = $urandom;
    end
    idle();
    repeat (3) @(negedge clk);
    check("if_q_drained", exp_if_q.size(), 0);
    check("d_q_drained", exp_d_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "time limit");
  end
endmodule
